hilo_acc: RTL

//  Downstream stage of the sequential signed multiplier (mult). Captures the 64-bit
//  {higher,lower} product when mult signals completion and holds it in HI/LO registers.

---
 rtl/hilo_acc.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hilo_acc.sv
// HI/LO accumulator stage behind the sequential multiplier: loads, accumulates or subtracts 2W-bit products.
// Optional HILO_SAT_EN: saturate {hi,lo} on signed accumulate overflow instead of wrapping.
module hilo_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  input  logic [2:0]   op,
  input  logic [W-1:0] wdata,
  output logic         op_ready,
  input  logic         prod_valid,
  input  logic [W-1:0] prod_hi,
  input  logic [W-1:0] prod_lo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam logic [2:0] OP_MULT = 3'b001;
  localparam logic [2:0] OP_MADD = 3'b010;
  localparam logic [2:0] OP_MSUB = 3'b011;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT, ADDLO, ADDHI} state_t;

  state_t         state, state_nx;
  logic [2:0]     mode;
  logic [2*W-1:0] p;
  logic           c;

  logic           is_sub;
  logic [W-1:0]   b_lo, b_hi, lo_sum, hi_sum;
  logic           lo_c, v;

  assign op_ready = (state == IDLE);
  assign busy     = ~op_ready;
  assign is_sub   = (mode == OP_MSUB);

  // MSUB is an add of the two's complement: invert P and inject the +1 as the low-half carry-in
  always_comb begin
    b_lo = is_sub ? ~p[W-1:0] : p[W-1:0];
    b_hi = is_sub ? ~p[2*W-1:W] : p[2*W-1:W];
    {lo_c, lo_sum} = {1'b0, lo} + {1'b0, b_lo} + {{W{1'b0}}, is_sub};
    hi_sum = hi + b_hi + {{(W-1){1'b0}}, c};
    v = (hi[W-1] == b_hi[W-1]) && (hi_sum[W-1] != hi[W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (op_valid && (op == OP_MULT || op == OP_MADD || op == OP_MSUB)) state_nx = WAIT;
      WAIT:  if (prod_valid) state_nx = (mode == OP_MULT) ? IDLE : ADDLO;
      ADDLO: state_nx = ADDHI;
      ADDHI: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi   <= '0;
      lo   <= '0;
      ovf  <= 1'b0;
      done <= 1'b0;
      mode <= '0;
      p    <= '0;
      c    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (op_valid) begin
          case (op)
            OP_MTHI: hi <= wdata;
            OP_MTLO: lo <= wdata;
            OP_CLR: begin
              hi  <= '0;
              lo  <= '0;
              ovf <= 1'b0;
            end
            OP_MULT, OP_MADD, OP_MSUB: mode <= op;
            default: ;
          endcase
        end
        WAIT: if (prod_valid) begin
          p <= {prod_hi, prod_lo};
          if (mode == OP_MULT) begin
            hi   <= prod_hi;
            lo   <= prod_lo;
            done <= 1'b1;
          end
        end
        ADDLO: begin
          lo <= lo_sum;
          c  <= lo_c;
        end
        ADDHI: begin
          hi   <= hi_sum;
          done <= 1'b1;
          if (v) ovf <= 1'b1;
`ifdef HILO_SAT_EN
          // both operands share the old hi sign, which is the sign of the true result
          if (v) begin
            hi <= hi[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            lo <= hi[W-1] ? {W{1'b0}} : {W{1'b1}};
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
